// File: rtl/rxn_probe_gate.sv
// Capture qualifier in front of the rxn ILA: gates the (time, value) stream by arm, window,
// decimation, budget and, with RXN_PROBE_TRIG_EN defined, a rising level-crossing trigger.
module rxn_probe_gate #(
  parameter int unsigned TIME_WIDTH  = 64,
  parameter int unsigned VALUE_WIDTH = 18,
  parameter int unsigned DECIM_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [TIME_WIDTH-1:0]  in_time,
  input  logic [VALUE_WIDTH-1:0] in_value,
  input  logic                   arm,
  input  logic                   clear,
  input  logic [TIME_WIDTH-1:0]  t_start,
  input  logic [TIME_WIDTH-1:0]  t_stop,
  input  logic [DECIM_WIDTH-1:0] decim,
  input  logic [COUNT_WIDTH-1:0] max_samples,
  input  logic [VALUE_WIDTH-1:0] trig_level,
  output logic                   probe_valid,
  output logic [TIME_WIDTH-1:0]  probe_time,
  output logic [VALUE_WIDTH-1:0] probe_value,
  output logic                   probe_trig,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] sample_count,
  output logic                   done
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArmed    = 3'd1,
    StWaitTrig = 3'd2,
    StCapture  = 3'd3,
    StDone     = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [DECIM_WIDTH-1:0] phase_q, phase_d;
  logic                   pvalid_q, pvalid_d;
  logic [TIME_WIDTH-1:0]  ptime_q, ptime_d;
  logic [VALUE_WIDTH-1:0] pvalue_q, pvalue_d;
  logic                   ptrig_q, ptrig_d;

  logic [DECIM_WIDTH:0]   decim_eff;
  logic [DECIM_WIDTH:0]   phase_inc;
  logic [COUNT_WIDTH:0]   count_inc;
  logic                   cap_go;
  logic                   trig_hit;

`ifdef RXN_PROBE_TRIG_EN
  logic [VALUE_WIDTH-1:0] prev_q, prev_d;
  logic                   prev_vld_q, prev_vld_d;
`else
  logic unused_trig;
  assign unused_trig = ^trig_level;
`endif

  assign decim_eff = (decim == '0) ? (DECIM_WIDTH+1)'(1) : {1'b0, decim};
  assign phase_inc = {1'b0, phase_q} + (DECIM_WIDTH+1)'(1);
  assign count_inc = {1'b0, count_q} + (COUNT_WIDTH+1)'(1);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    phase_d  = phase_q;
    pvalid_d = 1'b0;
    ptime_d  = ptime_q;
    pvalue_d = pvalue_q;
    ptrig_d  = 1'b0;
    cap_go   = 1'b0;
    trig_hit = 1'b0;
`ifdef RXN_PROBE_TRIG_EN
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          state_d = StArmed;
          count_d = '0;
          phase_d = '0;
`ifdef RXN_PROBE_TRIG_EN
          prev_vld_d = 1'b0;
`endif
        end
      end
      StArmed: begin
        if (in_valid) begin
`ifdef RXN_PROBE_TRIG_EN
          prev_d     = in_value;
          prev_vld_d = 1'b1;
          if (in_time >= t_start) state_d = StWaitTrig;
`else
          // The window-opening sample is itself the first capture candidate.
          if (in_time >= t_start) cap_go = 1'b1;
`endif
        end
      end
      StWaitTrig: begin
`ifdef RXN_PROBE_TRIG_EN
        if (in_valid) begin
          prev_d     = in_value;
          prev_vld_d = 1'b1;
          if (in_time >= t_stop) begin
            state_d = StDone;
          end else if (prev_vld_q && ($signed(prev_q) < $signed(trig_level)) &&
                       ($signed(in_value) >= $signed(trig_level))) begin
            cap_go   = 1'b1;
            trig_hit = 1'b1;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StCapture: begin
        if (in_valid) cap_go = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (cap_go) begin
      if (in_time >= t_stop) begin
        state_d = StDone;
      end else begin
        state_d = StCapture;
        phase_d = (phase_inc >= decim_eff) ? '0 : phase_inc[DECIM_WIDTH-1:0];
        if (phase_q == '0) begin
          pvalid_d = 1'b1;
          ptime_d  = in_time;
          pvalue_d = in_value;
`ifdef RXN_PROBE_TRIG_EN
          ptrig_d  = trig_hit;
`else
          ptrig_d  = (count_q == '0);
`endif
          // Saturate rather than wrap when running without a budget.
          count_d = count_inc[COUNT_WIDTH] ? count_q : count_inc[COUNT_WIDTH-1:0];
          if ((max_samples != '0) && (count_inc == {1'b0, max_samples})) state_d = StDone;
        end
      end
    end

    if (clear) begin
      state_d  = StIdle;
      count_d  = count_q;
      phase_d  = phase_q;
      pvalid_d = 1'b0;
      ptime_d  = ptime_q;
      pvalue_d = pvalue_q;
      ptrig_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      phase_q  <= '0;
      pvalid_q <= 1'b0;
      ptime_q  <= '0;
      pvalue_q <= '0;
      ptrig_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      pvalid_q <= pvalid_d;
      ptime_q  <= ptime_d;
      pvalue_q <= pvalue_d;
      ptrig_q  <= ptrig_d;
    end
  end

`ifdef RXN_PROBE_TRIG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`endif

  assign probe_valid  = pvalid_q;
  assign probe_time   = ptime_q;
  assign probe_value  = pvalue_q;
  assign probe_trig   = ptrig_q;
  assign state        = state_q;
  assign sample_count = count_q;
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_rxn_probe_gate.sv
// Directed bench for rxn_probe_gate; the trigger scenario runs when RXN_PROBE_TRIG_EN is defined.
module tb_rxn_probe_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_time;
  logic [17:0] in_value;
  logic        arm;
  logic        clear;
  logic [63:0] t_start;
  logic [63:0] t_stop;
  logic [7:0]  decim;
  logic [15:0] max_samples;
  logic [17:0] trig_level;
  logic        probe_valid;
  logic [63:0] probe_time;
  logic [17:0] probe_value;
  logic        probe_trig;
  logic [2:0]  state;
  logic [15:0] sample_count;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;

  always #5 clk = ~clk;

  rxn_probe_gate dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_time      (in_time),
    .in_value     (in_value),
    .arm          (arm),
    .clear        (clear),
    .t_start      (t_start),
    .t_stop       (t_stop),
    .decim        (decim),
    .max_samples  (max_samples),
    .trig_level   (trig_level),
    .probe_valid  (probe_valid),
    .probe_time   (probe_time),
    .probe_value  (probe_value),
    .probe_trig   (probe_trig),
    .state        (state),
    .sample_count (sample_count),
    .done         (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] t, input logic [17:0] v);
    in_valid = 1'b1;
    in_time  = t;
    in_value = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic config_set(input logic [63:0] ts, input logic [63:0] te, input logic [7:0] d,
                            input logic [15:0] m);
    t_start     = ts;
    t_stop      = te;
    decim       = d;
    max_samples = m;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'bx; in_time = 'x; in_value = 'x;
    arm = 1'b0; clear = 1'b0;
    config_set(64'd0, 64'd0, 8'd1, 16'd0);
    trig_level = '0;

    // Reset with X on the sample inputs
    repeat (3) tick();
    check_eq("rst_pv",    probe_valid,  0);
    check_eq("rst_ptime", probe_time,   0);
    check_eq("rst_pval",  probe_value,  0);
    check_eq("rst_ptrig", probe_trig,   0);
    check_eq("rst_state", state,        0);
    check_eq("rst_count", sample_count, 0);
    check_eq("rst_done",  done,         0);
    rst = 1'b0;
    in_valid = 1'b0; in_time = '0; in_value = '0;
    tick();

`ifndef RXN_PROBE_TRIG_EN
    // Window [10,20), decim 1, unlimited
    config_set(64'd10, 64'd20, 8'd1, 16'd0);
    do_arm();
    check_eq("t2_armed", state, 1);
    pulses = 0;
    for (int t = 0; t <= 30; t++) begin
      send(64'(t), 18'(t));
      if (probe_valid === 1'b1) pulses++;
      check_eq("t2_pv", probe_valid, (t >= 10 && t < 20) ? 1 : 0);
      if (t >= 10 && t < 20) begin
        check_eq("t2_ptime", probe_time, 64'(t));
        check_eq("t2_ptrig", probe_trig, (t == 10) ? 1 : 0);
      end
      if (t == 19) check_eq("t2_notdone", done, 0);
      if (t == 20) check_eq("t2_done", done, 1);
    end
    check_eq("t2_pulses", 64'(pulses), 10);
    check_eq("t2_count", sample_count, 10);

    // Decim 3, budget 4
    config_set(64'd0, 64'd1000, 8'd3, 16'd4);
    do_arm();
    check_eq("t3_rearm_count", sample_count, 0);
    for (int t = 0; t <= 99; t++) begin
      send(64'(t), 18'(t));
      check_eq("t3_pv", probe_valid, ((t % 3) == 0 && t <= 9) ? 1 : 0);
      if ((t % 3) == 0 && t <= 9) begin
        check_eq("t3_ptime", probe_time, 64'(t));
        check_eq("t3_ptrig", probe_trig, (t == 0) ? 1 : 0);
      end
    end
    check_eq("t3_count", sample_count, 4);
    check_eq("t3_state", state, 4);
    check_eq("t3_done",  done,  1);

    // decim 0 acts as 1, max 0 never stops
    config_set(64'd0, 64'd1000, 8'd0, 16'd0);
    do_arm();
    check_eq("t4_count0", sample_count, 0);
    check_eq("t4_armed",  state, 1);
    for (int t = 200; t <= 209; t++) begin
      send(64'(t), 18'(t + 5));
      check_eq("t4_pv",    probe_valid, 1);
      check_eq("t4_ptime", probe_time, 64'(t));
      check_eq("t4_pval",  probe_value, 64'(t + 5));
      check_eq("t4_ptrig", probe_trig, (t == 200) ? 1 : 0);
    end
    check_eq("t4_count", sample_count, 10);
    check_eq("t4_state", state, 3);

    // Clear with a coincident sample and arm: clear wins, no pulse, count kept
    clear = 1'b1;
    arm   = 1'b1;
    send(64'd210, 18'd7);
    clear = 1'b0;
    arm   = 1'b0;
    check_eq("t6_pv",    probe_valid, 0);
    check_eq("t6_state", state, 0);
    check_eq("t6_count", sample_count, 10);
    check_eq("t6_ptime_hold", probe_time, 209);
    do_arm();
    check_eq("t6_rearm_count", sample_count, 0);
    check_eq("t6_rearm_state", state, 1);

    // Empty window ends capture without emission
    config_set(64'd50, 64'd50, 8'd1, 16'd0);
    send(64'd300, 18'd1);
    check_eq("tw_pv",    probe_valid, 0);
    check_eq("tw_state", state, 4);
    check_eq("tw_count", sample_count, 0);
`else
    begin
      int vals[6] = '{50, 99, 100, 150, 80, 120};
      trig_level = 18'd100;
      config_set(64'd0, 64'd1000, 8'd1, 16'd0);
      do_arm();
      for (int i = 0; i < 6; i++) begin
        send(64'(i), 18'(vals[i]));
        check_eq("t5_pv", probe_valid, (i >= 2) ? 1 : 0);
        if (i == 0) check_eq("t5_waittrig", state, 2);
        if (i >= 2) begin
          check_eq("t5_pval",  probe_value, 64'(vals[i]));
          check_eq("t5_ptrig", probe_trig, (i == 2) ? 1 : 0);
        end
      end
      check_eq("t5_count", sample_count, 4);
      check_eq("t5_state", state, 3);
      clear = 1'b1;
      send(64'd6, 18'd200);
      clear = 1'b0;
      check_eq("t5_clr_pv",    probe_valid, 0);
      check_eq("t5_clr_state", state, 0);
      check_eq("t5_clr_count", sample_count, 4);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
